conv_pool2x2: RTL and testbench

- Downstream neighbour of the 3-kernel convolution top.
- Consumes the three 30x30 convolution result maps as a lockstep raster stream, one pixel per channel per beat.
- Performs 2x2 stride-2 max pooling and emits three 15x15 maps as a raster stream with a valid/ready handshake.
- Output feeds the next layer's buffer.

---
 rtl/conv_pool2x2.sv | 128 ++++++++++++
 tb/tb_conv_pool2x2.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pool2x2.sv
`default_nettype none
// ============================================================================
// Module   : conv_pool2x2
// Purpose  : 2x2 stride-2 signed max pooling over three lockstep raster maps;
//            POOL_RELU_EN fuses a ReLU clamp onto each pooled output.
// Revision : 1.0 - initial release
// ============================================================================
module conv_pool2x2 #(
    parameter int WIDTH  = 9,
    parameter int IN_DIM = 30
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic             out_last,
    output logic             frame_done
);
    localparam int OUT_DIM = IN_DIM / 2;
    localparam int c_CW    = $clog2(IN_DIM);
    localparam int c_IW    = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(IN_DIM - 1);

    logic [c_CW-1:0]         r_col;
    logic [c_CW-1:0]         r_row;
    logic signed [WIDTH-1:0] r_h   [3];
    logic signed [WIDTH-1:0] r_rb  [3][OUT_DIM];
    logic signed [WIDTH-1:0] r_out [3];
    logic signed [WIDTH-1:0] w_in  [3];
    logic signed [WIDTH-1:0] w_pair[3];
    logic signed [WIDTH-1:0] w_win [3];
    logic signed [WIDTH-1:0] w_res [3];
    logic [c_IW-1:0]         w_idx;
    logic                    w_accept;
    logic                    w_load;
    logic                    w_last_pix;

    function automatic logic signed [WIDTH-1:0] smax(input logic signed [WIDTH-1:0] a,
                                                     input logic signed [WIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

    assign w_in[0] = in_data0;
    assign w_in[1] = in_data1;
    assign w_in[2] = in_data2;

    assign in_ready   = !(out_valid && !out_ready);
    assign w_accept   = in_valid && in_ready && !clear;
    assign w_load     = w_accept && r_col[0] && r_row[0];
    assign w_last_pix = (r_col == c_LAST) && (r_row == c_LAST);
    assign w_idx      = c_IW'(r_col >> 1);
    assign frame_done = out_valid && out_ready && out_last;

    assign out_data0 = r_out[0];
    assign out_data1 = r_out[1];
    assign out_data2 = r_out[2];

    always_comb begin
        for (int ch = 0; ch < 3; ch++) begin
            w_pair[ch] = smax(r_h[ch], w_in[ch]);
            w_win[ch]  = smax(r_rb[ch][w_idx], w_pair[ch]);
`ifdef POOL_RELU_EN
            w_res[ch]  = w_win[ch][WIDTH-1] ? '0 : w_win[ch];
`else
            w_res[ch]  = w_win[ch];
`endif
        end
    end

    // Raster position of the next beat to be accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (clear) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (r_col == c_LAST) begin
                r_col <= '0;
                r_row <= (r_row == c_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Pair and row-buffer storage carries no reset: contents are always
    // rewritten before use within a frame.
    always_ff @(posedge clk) begin
        for (int ch = 0; ch < 3; ch++) begin
            if (w_accept && !r_col[0])
                r_h[ch] <= w_in[ch];
            if (w_accept && r_col[0] && !r_row[0])
                r_rb[ch][w_idx] <= w_pair[ch];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            for (int ch = 0; ch < 3; ch++)
                r_out[ch] <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (w_load) begin
            out_valid <= 1'b1;
            out_last  <= w_last_pix;
            for (int ch = 0; ch < 3; ch++)
                r_out[ch] <= w_res[ch];
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_conv_pool2x2.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_pool2x2
// Purpose  : Scoreboard bench for conv_pool2x2 (honours POOL_RELU_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_pool2x2;
    logic       clk = 1'b0;
    logic       rst_n, clear, in_valid, in_ready, out_valid, out_ready;
    logic       out_last, frame_done;
    logic [8:0] in_data0, in_data1, in_data2;
    logic [8:0] out_data0, out_data1, out_data2;

    typedef struct packed {
        logic [8:0] d0;
        logic [8:0] d1;
        logic [8:0] d2;
        logic       last;
    } exp_t;

    exp_t              q[$];
    logic signed [8:0] img[3][30][30];
    int                total = 0, bad = 0;
    int                out_cnt = 0, fd_cnt = 0;
    int                m_row = 0, m_col = 0;
    int                drv_pos = 0;
    int                rdy_mode = 0;

    conv_pool2x2 #(.WIDTH(9), .IN_DIM(30)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2),
        .out_last(out_last), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] pool_ref(input int ch, input int r, input int c);
        logic signed [8:0] m;
        m = img[ch][r][c];
        if (img[ch][r][c+1] > m)   m = img[ch][r][c+1];
        if (img[ch][r+1][c] > m)   m = img[ch][r+1][c];
        if (img[ch][r+1][c+1] > m) m = img[ch][r+1][c+1];
`ifdef POOL_RELU_EN
        if (m < 0) m = '0;
`endif
        return m;
    endfunction

    task automatic fill(input bit ramp);
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 30; c++)
                for (int ch = 0; ch < 3; ch++)
                    img[ch][r][c] = (ramp && ch == 0) ? 9'((r * 30 + c) % 256)
                                                      : 9'($urandom_range(0, 511));
    endtask

    // out_ready generator: 0 = always ready, 1 = random, 2 = test-controlled
    initial forever begin
        @(posedge clk); #1;
        if (rdy_mode == 0)      out_ready = 1'b1;
        else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
    end

    // Scoreboard: push on window completion, pop on output handshake.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            q.delete(); m_row = 0; m_col = 0;
        end else begin
            if (out_valid && out_ready) begin
                out_cnt++;
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL beat_unexpected: got d0=%0d d1=%0d d2=%0d, required no beat",
                             out_data0, out_data1, out_data2);
                end else begin
                    e = q.pop_front();
                    if ({out_data0, out_data1, out_data2, out_last, frame_done} !==
                        {e.d0, e.d1, e.d2, e.last, e.last}) begin
                        bad++;
                        $display("FAIL beat_%0d: got %h/%h/%h last=%b fd=%b, required %h/%h/%h last=%b fd=%b",
                                 out_cnt, out_data0, out_data1, out_data2, out_last, frame_done,
                                 e.d0, e.d1, e.d2, e.last, e.last);
                    end
                end
            end else if (frame_done) begin
                total++; bad++;
                $display("FAIL frame_done_stray: got 1, required 0");
            end
            if (frame_done) fd_cnt++;
            if (clear) begin
                q.delete(); m_row = 0; m_col = 0;
            end else if (in_valid && in_ready) begin
                if ((m_row % 2 == 1) && (m_col % 2 == 1)) begin
                    e.d0 = pool_ref(0, m_row - 1, m_col - 1);
                    e.d1 = pool_ref(1, m_row - 1, m_col - 1);
                    e.d2 = pool_ref(2, m_row - 1, m_col - 1);
                    e.last = (m_row == 29) && (m_col == 29);
                    q.push_back(e);
                end
                if (m_col == 29) begin
                    m_col = 0;
                    m_row = (m_row == 29) ? 0 : m_row + 1;
                end else m_col++;
            end
        end
    end

    task automatic drive_pixels(input int n, input int gap);
        int k = 0, guard = 0;
        bit acc;
        while (k < n) begin
            if (int'($urandom_range(0, 99)) < gap) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end else begin
                in_valid = 1'b1;
                in_data0 = img[0][drv_pos / 30][drv_pos % 30];
                in_data1 = img[1][drv_pos / 30][drv_pos % 30];
                in_data2 = img[2][drv_pos / 30][drv_pos % 30];
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
                if (acc) begin
                    k++; guard = 0;
                    drv_pos = (drv_pos + 1) % 900;
                end else if (++guard > 2000) begin
                    total++; bad++;
                    $display("FAIL drive_timeout: got in_ready=0 for 2000 cycles, required 1");
                    k = n;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200; i++) begin
            if (q.size() == 0 && !out_valid) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_data0 = '0; in_data1 = '0; in_data2 = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
        total++; if (out_data0 !== 9'd0)  begin bad++; $display("FAIL rst_out_data0: got %h, required 0", out_data0); end
        total++; if (out_data1 !== 9'd0)  begin bad++; $display("FAIL rst_out_data1: got %h, required 0", out_data1); end
        total++; if (out_data2 !== 9'd0)  begin bad++; $display("FAIL rst_out_data2: got %h, required 0", out_data2); end
        total++; if (out_last !== 1'b0)   begin bad++; $display("FAIL rst_out_last: got %b, required 0", out_last); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done: got %b, required 0", frame_done); end
        total++; if (in_ready !== 1'b1)   begin bad++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ramp();
        int c0 = out_cnt, f0 = fd_cnt;
        fill(1'b1);
        rdy_mode = 0; drv_pos = 0;
        drive_pixels(900, 0);
        wait_drain();
        total++; if (out_cnt - c0 !== 225) begin bad++; $display("FAIL ramp_beats: got %0d, required 225", out_cnt - c0); end
        total++; if (fd_cnt - f0 !== 1)    begin bad++; $display("FAIL ramp_frame_done: got %0d, required 1", fd_cnt - f0); end
        total++; if (q.size() !== 0)       begin bad++; $display("FAIL ramp_leftover: got %0d, required 0", q.size()); end
    endtask

    task automatic test_sign();
        logic [8:0] want;
`ifdef POOL_RELU_EN
        want = 9'd0;
`else
        want = 9'h1FD;
`endif
        fill(1'b0);
        img[1][0][0] = -9'sd5;  img[1][0][1] = -9'sd3;
        img[1][1][0] = -9'sd7;  img[1][1][1] = -9'sd100;
        rdy_mode = 0; drv_pos = 0;
        drive_pixels(32, 0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sign_valid: got %b, required 1", out_valid); end
        total++; if (out_data1 !== want) begin bad++; $display("FAIL sign_data1: got %h, required %h", out_data1, want); end
        drive_pixels(868, 0);
        wait_drain();
        total++; if (q.size() !== 0) begin bad++; $display("FAIL sign_leftover: got %0d, required 0", q.size()); end
    endtask

    task automatic test_backpressure();
        int c0 = out_cnt, f0 = fd_cnt;
        logic [26:0] held;
        fill(1'b0);
        rdy_mode = 2; out_ready = 1'b1; drv_pos = 0;
        fork
            drive_pixels(900, 0);
            begin
                for (int i = 0; i < 200; i++) begin
                    @(posedge clk); #2;
                    if (out_valid) break;
                end
                out_ready = 1'b0;
                held = {out_data0, out_data1, out_data2};
                for (int i = 0; i < 5; i++) begin
                    @(posedge clk); #2;
                    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b, required 0", in_ready); end
                    total++; if ({out_valid, out_data0, out_data1, out_data2} !== {1'b1, held}) begin
                        bad++; $display("FAIL bp_hold: got v=%b %h, required v=1 %h",
                                        out_valid, {out_data0, out_data1, out_data2}, held);
                    end
                end
                out_ready = 1'b1;
                rdy_mode = 0;
            end
        join
        wait_drain();
        total++; if (out_cnt - c0 !== 225) begin bad++; $display("FAIL bp_beats: got %0d, required 225", out_cnt - c0); end
        total++; if (fd_cnt - f0 !== 1)    begin bad++; $display("FAIL bp_frame_done: got %0d, required 1", fd_cnt - f0); end
    endtask

    task automatic test_random();
        int c0 = out_cnt, f0 = fd_cnt;
        fill(1'b0);
        rdy_mode = 1; drv_pos = 0;
        drive_pixels(900, 50);
        rdy_mode = 0;
        wait_drain();
        total++; if (out_cnt - c0 !== 225) begin bad++; $display("FAIL rand_beats: got %0d, required 225", out_cnt - c0); end
        total++; if (fd_cnt - f0 !== 1)    begin bad++; $display("FAIL rand_frame_done: got %0d, required 1", fd_cnt - f0); end
    endtask

    task automatic test_clear();
        int c0, f0;
        fill(1'b0);
        rdy_mode = 0; drv_pos = 0;
        drive_pixels(12 * 30 + 7, 0);
        in_valid = 1'b1; clear = 1'b1;
        in_data0 = img[0][12][7]; in_data1 = img[1][12][7]; in_data2 = img[2][12][7];
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clr_out_valid: got %b, required 0", out_valid); end
        total++; if (out_last !== 1'b0)  begin bad++; $display("FAIL clr_out_last: got %b, required 0", out_last); end
        c0 = out_cnt; f0 = fd_cnt;
        fill(1'b0);
        drv_pos = 0;
        drive_pixels(900, 0);
        wait_drain();
        total++; if (out_cnt - c0 !== 225) begin bad++; $display("FAIL clr_beats: got %0d, required 225", out_cnt - c0); end
        total++; if (fd_cnt - f0 !== 1)    begin bad++; $display("FAIL clr_frame_done: got %0d, required 1", fd_cnt - f0); end
    endtask

    task automatic test_back_to_back();
        int c0, f0;
        fill(1'b0);
        rdy_mode = 2; out_ready = 1'b0; drv_pos = 0;
        drive_pixels(32, 0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_held_valid: got %b, required 1", out_valid); end
        rst_n = 1'b0;
        #1;
        total++; if ({out_valid, out_last, frame_done} !== 3'b000) begin
            bad++; $display("FAIL mid_rst_ctrl: got %b, required 000", {out_valid, out_last, frame_done});
        end
        total++; if ({out_data0, out_data1, out_data2} !== 27'd0) begin
            bad++; $display("FAIL mid_rst_data: got %h, required 0", {out_data0, out_data1, out_data2});
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; rdy_mode = 0; out_ready = 1'b1;
        c0 = out_cnt; f0 = fd_cnt; drv_pos = 0;
        drive_pixels(1800, 0);
        wait_drain();
        total++; if (out_cnt - c0 !== 450) begin bad++; $display("FAIL b2b_beats: got %0d, required 450", out_cnt - c0); end
        total++; if (fd_cnt - f0 !== 2)    begin bad++; $display("FAIL b2b_frame_done: got %0d, required 2", fd_cnt - f0); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_sign();
        test_backpressure();
        test_random();
        test_clear();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
